// File: rtl/gated_delay_pipe_if.sv
// Bundles the gated delay pipe's data, control and status signals.
// The bench drives through the master side; the pipe sits on the slave side.
interface gated_delay_pipe_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] aux;
  logic             mode;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             hit;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output en, a, b, aux, mode, clr,
    input  q, q_valid, hit, hit_cnt
  );

  modport slave (
    input  en, a, b, aux, mode, clr,
    output q, q_valid, hit, hit_cnt
  );
endinterface

// File: rtl/gated_delay_pipe.sv
// Multi-lane gated flop chain: (a & b) | delayed aux feeds an enable-gated pipe,
// with an optional sticky first stage and a saturating consecutive-activity trigger.
module gated_delay_pipe #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int AUX_DEPTH = 2,
  parameter int CNT_W     = 4,
  parameter int THRESH    = 8
) (
  input  logic             CLK,
  input  logic             RSTB,
  gated_delay_pipe_if.slave io_bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic [WIDTH-1:0] r_aux  [AUX_DEPTH];
  logic [WIDTH-1:0] r_pipe [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CNT_W-1:0] r_hit_cnt;
  logic             r_hit;

  logic [WIDTH-1:0] w_aux_d;
  logic [WIDTH-1:0] w_gate;
  logic [WIDTH-1:0] w_stage0_next;
  logic             w_active;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_hit_next;

  // The aux chain free-runs: neither en, mode nor clr touches it.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < AUX_DEPTH; i++) r_aux[i] <= '0;
    end else begin
      r_aux[0] <= io_bus.aux;
      for (int i = 1; i < AUX_DEPTH; i++) r_aux[i] <= r_aux[i-1];
    end
  end

  assign w_aux_d       = r_aux[AUX_DEPTH-1];
  assign w_gate        = (io_bus.a & io_bus.b) | w_aux_d;
  assign w_stage0_next = io_bus.mode ? (r_pipe[0] | w_gate) : w_gate;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (io_bus.clr) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else if (io_bus.en) begin
      r_pipe[0] <= w_stage0_next;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_valid <= '0;
    end else if (io_bus.clr) begin
      r_valid <= '0;
    end else if (io_bus.en) begin
      r_valid[0] <= 1'b1;
      for (int i = 1; i < DEPTH; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  // Only the a&b term counts as activity; aux never advances the trigger.
  assign w_active = io_bus.en & (|(io_bus.a & io_bus.b));

  always_comb begin
    w_cnt_next = r_hit_cnt;
    w_hit_next = r_hit;
    if (io_bus.clr) begin
      w_cnt_next = '0;
      w_hit_next = 1'b0;
    end else begin
      if (io_bus.en) begin
        if (w_active) begin
          w_cnt_next = (r_hit_cnt == CNT_MAX) ? CNT_MAX : r_hit_cnt + 1'b1;
        end else begin
          w_cnt_next = '0;
        end
      end
      if (w_cnt_next >= THRESH_C) w_hit_next = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_hit_cnt <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_hit_cnt <= w_cnt_next;
      r_hit     <= w_hit_next;
    end
  end

  assign io_bus.q       = r_pipe[DEPTH-1];
  assign io_bus.q_valid = r_valid[DEPTH-1];
  assign io_bus.hit     = r_hit;
  assign io_bus.hit_cnt = r_hit_cnt;

endmodule
